// File: rtl/cpu_test_harness_if.sv
// cpu_test_harness_if: CPU-side bus between the harness memories and the core under test
interface cpu_test_harness_if #(parameter int XLEN = 32);
    logic            cpu_rst;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] read_data;
    logic [XLEN-1:0] write_data;
    logic            mem_write;
    logic [XLEN-1:0] pc_addres;
    logic [XLEN-1:0] addres;
    modport master (output cpu_rst, instruction, read_data, input write_data, mem_write, pc_addres, addres);
    modport slave  (input cpu_rst, instruction, read_data, output write_data, mem_write, pc_addres, addres);
endinterface

// File: rtl/cpu_test_harness.sv
// cpu_test_harness: memories, reset sequencing, run control and store trace around a single-cycle CPU.
// Optional macro TRACE_CHECK_EN adds loadable expected-trace arrays and a sticky mismatch flag.
module cpu_test_harness #(
    parameter int XLEN        = 32,
    parameter int IMEM_DEPTH  = 64,
    parameter int DMEM_DEPTH  = 64,
    parameter int TRACE_DEPTH = 16,
    parameter int RST_CYCLES  = 2,
    parameter int MAX_CYCLES  = 1024,
    localparam int IAW = $clog2(IMEM_DEPTH),
    localparam int DAW = $clog2(DMEM_DEPTH),
    localparam int TAW = $clog2(TRACE_DEPTH),
    localparam int LAW = (IAW > DAW) ? ((IAW > TAW) ? IAW : TAW) : ((DAW > TAW) ? DAW : TAW)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [XLEN-1:0]     halt_pc_i,
    input  logic                load_we_i,
    input  logic [1:0]          load_sel_i,
    input  logic [LAW-1:0]      load_addr_i,
    input  logic [XLEN-1:0]     load_data_i,
    cpu_test_harness_if.master  bus,
    output logic                busy_o,
    output logic                done_o,
    output logic                timeout_o,
    output logic [31:0]         cycle_cnt_o,
    output logic [TAW:0]        trace_cnt_o,
    output logic                trace_ovf_o,
    input  logic [TAW-1:0]      trace_rd_idx_i,
    output logic [XLEN-1:0]     trace_rd_addr_o,
    output logic [XLEN-1:0]     trace_rd_data_o,
    output logic                mismatch_o
);
    typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;
    localparam int RCW = $clog2(RST_CYCLES + 1);

    state_t          state_q, state_d;
    logic [RCW-1:0]  rcnt_q, rcnt_d;
    logic [31:0]     cyc_q, cyc_d;
    logic [TAW:0]    tcnt_q, tcnt_d;
    logic            to_q, to_d, ovf_q, ovf_d, mis_q, mis_d;
    logic [XLEN-1:0] imem [IMEM_DEPTH];
    logic [XLEN-1:0] dmem [DMEM_DEPTH];
    logic [XLEN-1:0] trace_addr [TRACE_DEPTH];
    logic [XLEN-1:0] trace_data [TRACE_DEPTH];
    logic            loading, storing, trace_full, trace_we, trace_miss;

    assign loading    = load_we_i && (state_q == IDLE || state_q == DONE);
    assign storing    = bus.mem_write && state_q == RUN;
    assign trace_full = tcnt_q == (TAW+1)'(TRACE_DEPTH);
    assign trace_we   = storing && !trace_full;

`ifdef TRACE_CHECK_EN
    logic [XLEN-1:0] exp_addr [TRACE_DEPTH];
    logic [XLEN-1:0] exp_data [TRACE_DEPTH];
    assign trace_miss = exp_addr[tcnt_q[TAW-1:0]] != bus.addres || exp_data[tcnt_q[TAW-1:0]] != bus.write_data;
`else
    assign trace_miss = 1'b0;
`endif

    assign bus.cpu_rst     = state_q != RUN;
    assign bus.instruction = imem[bus.pc_addres[IAW+1:2]];
    assign bus.read_data   = dmem[bus.addres[DAW+1:2]];
    assign busy_o          = state_q == RESET || state_q == RUN;
    assign done_o          = state_q == DONE;
    assign timeout_o       = to_q;
    assign cycle_cnt_o     = cyc_q;
    assign trace_cnt_o     = tcnt_q;
    assign trace_ovf_o     = ovf_q;
    assign mismatch_o      = mis_q;
    assign trace_rd_addr_o = trace_addr[trace_rd_idx_i];
    assign trace_rd_data_o = trace_data[trace_rd_idx_i];

    // Next-state: start clears run status, RESET counts out the CPU reset, RUN counts/traces until halt or budget
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        cyc_d   = cyc_q;
        tcnt_d  = tcnt_q;
        to_d    = to_q;
        ovf_d   = ovf_q;
        mis_d   = mis_q;
        case (state_q)
            RESET: begin
                rcnt_d = rcnt_q + RCW'(1);
                if (rcnt_q == RCW'(RST_CYCLES - 1)) state_d = RUN;
            end
            RUN: begin
                cyc_d = cyc_q + 32'd1;
                if (trace_we) tcnt_d = tcnt_q + (TAW+1)'(1);
                if (trace_we && trace_miss) mis_d = 1'b1;
                if (storing && trace_full) ovf_d = 1'b1;
                if (bus.pc_addres == halt_pc_i) begin
                    state_d = DONE;
                    to_d    = 1'b0;
                end else if (cyc_q == 32'(MAX_CYCLES - 1)) begin
                    state_d = DONE;
                    to_d    = 1'b1;
                end
            end
            default: begin
                if (start_i) begin
                    state_d = RESET;
                    rcnt_d  = '0;
                    cyc_d   = '0;
                    tcnt_d  = '0;
                    to_d    = 1'b0;
                    ovf_d   = 1'b0;
                    mis_d   = 1'b0;
                end
            end
        endcase
    end

    // Control registers; rst aborts any run straight back to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
            cyc_q   <= '0;
            tcnt_q  <= '0;
            to_q    <= 1'b0;
            ovf_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            cyc_q   <= cyc_d;
            tcnt_q  <= tcnt_d;
            to_q    <= to_d;
            ovf_q   <= ovf_d;
            mis_q   <= mis_d;
        end
    end

    // Memory arrays: preloads only when idle, CPU stores and trace capture only in RUN; contents survive rst
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (loading && load_sel_i == 2'd0) imem[load_addr_i[IAW-1:0]] <= load_data_i;
            if (loading && load_sel_i == 2'd1) dmem[load_addr_i[DAW-1:0]] <= load_data_i;
            if (storing) dmem[bus.addres[DAW+1:2]] <= bus.write_data;
            if (trace_we) begin
                trace_addr[tcnt_q[TAW-1:0]] <= bus.addres;
                trace_data[tcnt_q[TAW-1:0]] <= bus.write_data;
            end
`ifdef TRACE_CHECK_EN
            if (loading && load_sel_i == 2'd2) exp_addr[load_addr_i[TAW-1:0]] <= load_data_i;
            if (loading && load_sel_i == 2'd3) exp_data[load_addr_i[TAW-1:0]] <= load_data_i;
`endif
        end
    end
endmodule

// File: tb/tb_cpu_test_harness.sv
// tb_cpu_test_harness: bench plays the CPU on the bus and checks against a behavioural model
module tb_cpu_test_harness;
    localparam int MAXC = 1024;

    typedef struct {
        logic [31:0] pc;
        bit          we;
        bit          ld;
        bit          use_r;
        logic [31:0] addr;
        logic [31:0] data;
    } step_t;

    typedef struct {
        logic [1:0]  sel;
        logic [5:0]  la;
        logic [31:0] d;
        logic [31:0] rd;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 0, rst = 1, start = 0, load_we = 0;
    logic [31:0] halt_pc = 0, load_data = 0;
    logic [1:0]  load_sel = 0;
    logic [5:0]  load_addr = 0;
    logic        busy, done, timeout, trace_ovf, mismatch;
    logic [31:0] cycle_cnt, trace_rd_addr, trace_rd_data;
    logic [4:0]  trace_cnt;
    logic [3:0]  trace_rd_idx = 0;

    logic [31:0] m_imem [64];
    logic [31:0] m_dmem [64];
    logic [31:0] m_ea [16];
    logic [31:0] m_ed [16];
    logic [31:0] m_ta [$];
    logic [31:0] m_td [$];
    bit          m_ovf, m_mis, m_to;
    int          m_cyc;
    int          pass_cnt = 0, total = 0;
    step_t       prog [$];
    vec_t        tbl [6];

    cpu_test_harness_if #(.XLEN(32)) bus();

    cpu_test_harness dut (
        .clk(clk), .rst(rst), .start_i(start), .halt_pc_i(halt_pc),
        .load_we_i(load_we), .load_sel_i(load_sel), .load_addr_i(load_addr), .load_data_i(load_data),
        .bus(bus), .busy_o(busy), .done_o(done), .timeout_o(timeout), .cycle_cnt_o(cycle_cnt),
        .trace_cnt_o(trace_cnt), .trace_ovf_o(trace_ovf), .trace_rd_idx_i(trace_rd_idx),
        .trace_rd_addr_o(trace_rd_addr), .trace_rd_data_o(trace_rd_data), .mismatch_o(mismatch)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got still running, want finished");
        $fatal(1, "watchdog expired");
    end

    function automatic int wi(input logic [31:0] a);
        return int'((a >> 2) % 64);
    endfunction

    function automatic step_t mk(input logic [31:0] pc, input bit we, input bit ld, input bit ur,
                                 input logic [31:0] a, input logic [31:0] d);
        step_t s;
        s.pc = pc; s.we = we; s.ld = ld; s.use_r = ur; s.addr = a; s.data = d;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic load(input logic [1:0] sel, input logic [5:0] a, input logic [31:0] d);
        load_sel = sel; load_addr = a; load_data = d; load_we = 1;
        tick();
        load_we = 0;
        if (sel == 0) m_imem[a] = d;
        else if (sel == 1) m_dmem[a] = d;
`ifdef TRACE_CHECK_EN
        else if (sel == 2) m_ea[a % 16] = d;
        else m_ed[a % 16] = d;
`endif
    endtask

    task automatic model_clear();
        m_cyc = 0; m_ta.delete(); m_td.delete(); m_ovf = 0; m_mis = 0; m_to = 0;
    endtask

    task automatic do_start();
        int n = 0;
        start = 1;
        tick();
        start = 0;
        chk("start_cycle_clr", cycle_cnt, 0);
        chk("start_trace_clr", 32'(trace_cnt), 0);
        chk("start_to_clr", 32'(timeout), 0);
        chk("start_ovf_clr", 32'(trace_ovf), 0);
        chk("start_mis_clr", 32'(mismatch), 0);
        chk("start_busy", 32'(busy), 1);
        while (bus.cpu_rst && n < 10) begin
            n++;
            tick();
        end
        chk("rst_cycles", 32'(n), 2);
        model_clear();
    endtask

    task automatic run(input logic [31:0] halt, input int abort_at);
        logic [31:0] r = 0;
        bit fin = 0;
        halt_pc = halt;
        do_start();
        for (int i = 0; i < MAXC + 4 && !fin; i++) begin
            step_t s;
            s = (i < prog.size()) ? prog[i] : mk(32'(4 * i), 0, 0, 0, 0, 0);
            if (i == abort_at) begin
                bus.mem_write = 0; load_we = 0; rst = 1;
                tick();
                rst = 0;
                model_clear();
                chk("abort_cpu_rst", 32'(bus.cpu_rst), 1);
                chk("abort_busy", 32'(busy), 0);
                chk("abort_done", 32'(done), 0);
                chk("abort_cycle", cycle_cnt, 0);
                chk("abort_trace", 32'(trace_cnt), 0);
                return;
            end
            bus.pc_addres = s.pc; bus.mem_write = s.we; bus.addres = s.addr;
            bus.write_data = s.use_r ? r : s.data;
            load_we = (i == 1); load_sel = 0; load_addr = 7; load_data = ~m_imem[7];
            #1;
            chk("instr", bus.instruction, m_imem[wi(s.pc)]);
            if (s.ld) begin
                chk("load_data", bus.read_data, m_dmem[wi(s.addr)]);
                r = bus.read_data;
            end
            m_cyc++;
            if (s.we) begin
                m_dmem[wi(s.addr)] = bus.write_data;
                if (m_ta.size() < 16) begin
`ifdef TRACE_CHECK_EN
                    if (m_ea[m_ta.size()] != s.addr || m_ed[m_ta.size()] != bus.write_data) m_mis = 1;
`endif
                    m_ta.push_back(s.addr);
                    m_td.push_back(bus.write_data);
                end else m_ovf = 1;
            end
            if (s.pc == halt) begin fin = 1; m_to = 0; end
            else if (m_cyc == MAXC) begin fin = 1; m_to = 1; end
            tick();
            chk("done", 32'(done), 32'(fin));
        end
        bus.mem_write = 0; load_we = 0;
    endtask

    task automatic check_mems();
        for (int j = 0; j < 64; j++) begin
            bus.addres = 32'(j * 4); bus.pc_addres = 32'(j * 4);
            #1;
            chk("dmem_rd", bus.read_data, m_dmem[j]);
            chk("imem_rd", bus.instruction, m_imem[j]);
        end
    endtask

    task automatic verify();
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("cycle_cnt", cycle_cnt, 32'(m_cyc));
        chk("trace_cnt", 32'(trace_cnt), 32'(m_ta.size()));
        chk("trace_ovf", 32'(trace_ovf), 32'(m_ovf));
        chk("mismatch", 32'(mismatch), 32'(m_mis));
        chk("end_busy", 32'(busy), 0);
        chk("end_cpu_rst", 32'(bus.cpu_rst), 1);
        foreach (m_ta[k]) begin
            trace_rd_idx = 4'(k);
            #1;
            chk("trace_addr", trace_rd_addr, m_ta[k]);
            chk("trace_data", trace_rd_data, m_td[k]);
        end
        check_mems();
    endtask

    initial begin
        int len;
        int cnt;
        tbl[0] = '{2'd0, 6'd3,  32'hE580_1004, 32'h0000_010F, 32'hE580_1004};
        tbl[1] = '{2'd1, 6'd1,  32'hDEAD_BEEF, 32'h0000_0004, 32'hDEAD_BEEF};
        tbl[2] = '{2'd1, 6'd63, 32'h1234_5678, 32'hFFFF_FFFE, 32'h1234_5678};
        tbl[3] = '{2'd0, 6'd0,  32'hA0B0_C0D0, 32'h0000_0100, 32'hA0B0_C0D0};
        tbl[4] = '{2'd1, 6'd2,  32'h0000_0000, 32'h0000_0009, 32'h0000_0000};
        tbl[5] = '{2'd0, 6'd63, 32'hFFFF_FFFF, 32'h0000_00FC, 32'hFFFF_FFFF};
        bus.mem_write = 0; bus.pc_addres = 0; bus.addres = 0; bus.write_data = 0;
        model_clear();
        tick();
        tick();
        chk("rst_cpu_rst", 32'(bus.cpu_rst), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_cycle", cycle_cnt, 0);
        chk("rst_trace", 32'(trace_cnt), 0);
        chk("rst_ovf", 32'(trace_ovf), 0);
        chk("rst_mismatch", 32'(mismatch), 0);
        rst = 0;

        for (int j = 0; j < 64; j++) begin
            load(0, 6'(j), $urandom);
            load(1, 6'(j), $urandom);
        end
        for (int j = 0; j < 16; j++) begin
            load(2, 6'(j), $urandom);
            load(3, 6'(j), $urandom);
        end

        foreach (tbl[k]) begin
            load(tbl[k].sel, tbl[k].la, tbl[k].d);
            if (tbl[k].sel == 0) bus.pc_addres = tbl[k].rd;
            else bus.addres = tbl[k].rd;
            #1;
            chk("table_rd", (tbl[k].sel == 0) ? bus.instruction : bus.read_data, tbl[k].exp);
        end

        load(0, 0, 32'hE580_1004);
        prog.delete();
        prog.push_back(mk(32'h0, 1, 0, 0, 32'h4, 32'h11));
        prog.push_back(mk(32'h4, 0, 0, 0, 32'h0, 32'h0));
        prog.push_back(mk(32'h8, 0, 0, 0, 32'h0, 32'h0));
        run(32'h8, -1);
        chk("t1_done", 32'(done), 1);
        chk("t1_timeout", 32'(timeout), 0);
        chk("t1_cycles", cycle_cnt, 3);
        trace_rd_idx = 0;
        #1;
        chk("t1_trace_addr", trace_rd_addr, 32'h4);
        chk("t1_trace_data", trace_rd_data, 32'h11);
        verify();

        load(1, 1, 32'hDEAD_BEEF);
        prog.delete();
        prog.push_back(mk(32'h0, 0, 1, 0, 32'h4, 32'h0));
        prog.push_back(mk(32'h4, 1, 0, 1, 32'h8, 32'h0));
        prog.push_back(mk(32'h8, 0, 0, 0, 32'h0, 32'h0));
        run(32'h8, -1);
        bus.addres = 32'h8;
        trace_rd_idx = 0;
        #1;
        chk("t2_dmem2", bus.read_data, 32'hDEAD_BEEF);
        chk("t2_trace_addr", trace_rd_addr, 32'h8);
        chk("t2_trace_data", trace_rd_data, 32'hDEAD_BEEF);
        verify();

        prog.delete();
        for (int i = 0; i < 25; i++) prog.push_back(mk(32'(4 * i), 1, 0, 0, $urandom, $urandom));
        run(32'hFFFF_FFFC, -1);
        chk("t3_timeout", 32'(timeout), 1);
        chk("t3_cycles", cycle_cnt, 32'd1024);
        verify();

        prog.delete();
        run(32'(4 * 1023), -1);
        chk("halt_prio_timeout", 32'(timeout), 0);
        chk("halt_prio_cycles", cycle_cnt, 32'd1024);
        verify();

        prog.delete();
        for (int i = 0; i < 20; i++) prog.push_back(mk(32'(4 * i), 1, 0, 0, 32'(32'h40 + 4 * i), 32'(32'h1000 + i)));
        prog.push_back(mk(32'(4 * 20), 0, 0, 0, 0, 0));
        run(32'(4 * 20), -1);
        chk("t4_trace_cnt", 32'(trace_cnt), 16);
        chk("t4_ovf", 32'(trace_ovf), 1);
        bus.addres = 32'h40 + 4 * 19;
        #1;
        chk("t4_last_store", bus.read_data, 32'h1013);
        verify();

        prog.delete();
        for (int i = 0; i < 30; i++) prog.push_back(mk(32'(4 * i), 1, 0, 0, 32'(32'h80 + 4 * i), $urandom));
        run(32'hFFFF_FFFC, 10);
        chk("t5_timeout", 32'(timeout), 0);
        chk("t5_mismatch", 32'(mismatch), 0);
        check_mems();

        load(2, 0, 32'h4);
        load(3, 0, 32'h1);
        prog.delete();
        prog.push_back(mk(32'h0, 1, 0, 0, 32'h4, 32'h2));
        prog.push_back(mk(32'h4, 0, 0, 0, 32'h0, 32'h0));
        run(32'h4, -1);
`ifdef TRACE_CHECK_EN
        chk("t6_mismatch", 32'(mismatch), 1);
`else
        chk("t6_mismatch", 32'(mismatch), 0);
`endif
        verify();

        for (int r = 0; r < 6; r++) begin
            prog.delete();
            len = $urandom_range(5, 40);
            for (int i = 0; i < len; i++)
                prog.push_back(mk(32'(4 * i), bit'($urandom_range(0, 1)), 0, 0, $urandom, $urandom));
            cnt = 0;
            if (r % 2 == 0) begin
                foreach (prog[i]) begin
                    if (prog[i].we && cnt < 16) begin
                        load(2, 6'(cnt), prog[i].addr);
                        load(3, 6'(cnt), prog[i].data);
                        cnt++;
                    end
                end
            end
            for (int j = 0; j < 3; j++) load(1, 6'($urandom_range(0, 63)), $urandom);
            run(32'(4 * (len - 1)), -1);
            verify();
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
